// File: rtl/traffic_pkg.sv
// Shared light codes, direction indices, fault codes and helpers for the
// traffic conflict monitor.
package traffic_pkg;

   localparam int unsigned LIGHT_W = 2;
   localparam int unsigned DIR_W   = 2;
   localparam int unsigned CODE_W  = 3;
   localparam int unsigned VCNT_W  = 8;

   localparam logic [LIGHT_W-1:0] RED       = 2'b00;
   localparam logic [LIGHT_W-1:0] GREEN     = 2'b01;
   localparam logic [LIGHT_W-1:0] YELLOW    = 2'b10;
   localparam logic [LIGHT_W-1:0] BAD_LIGHT = 2'b11;

   localparam logic [DIR_W-1:0] NS = 2'd0;
   localparam logic [DIR_W-1:0] EW = 2'd1;
   localparam logic [DIR_W-1:0] SN = 2'd2;
   localparam logic [DIR_W-1:0] WE = 2'd3;

   localparam logic [CODE_W-1:0] FC_NONE          = 3'd0;
   localparam logic [CODE_W-1:0] FC_ILLEGAL_CODE  = 3'd1;
   localparam logic [CODE_W-1:0] FC_CONFLICT      = 3'd2;
   localparam logic [CODE_W-1:0] FC_BAD_SEQ       = 3'd3;
   localparam logic [CODE_W-1:0] FC_SHORT_GREEN   = 3'd4;
   localparam logic [CODE_W-1:0] FC_SHORT_YELLOW  = 3'd5;
   localparam logic [CODE_W-1:0] FC_DWELL_TIMEOUT = 3'd6;
   localparam logic [CODE_W-1:0] FC_BAD_ORDER     = 3'd7;

   // Sampled light vector; field order matches {ns, ew, sn, we}.
   typedef struct packed {
      logic [LIGHT_W-1:0] ns;
      logic [LIGHT_W-1:0] ew;
      logic [LIGHT_W-1:0] sn;
      logic [LIGHT_W-1:0] we;
   } light_vec_t;

   function automatic logic [LIGHT_W-1:0] dir_light(input light_vec_t v,
                                                    input logic [DIR_W-1:0] d);
      dir_light = v.ns;
      case (d)
         NS: dir_light = v.ns;
         EW: dir_light = v.ew;
         SN: dir_light = v.sn;
         WE: dir_light = v.we;
      endcase
   endfunction

   // Lowest set index of a per-direction mask; NS when the mask is empty.
   function automatic logic [DIR_W-1:0] low_idx(input logic [3:0] m);
      low_idx = NS;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) low_idx = DIR_W'(i);
      end
   endfunction

endpackage

// File: rtl/tlc_dir_checker.sv
// Per-direction light checks: illegal code, bad transition, short green and
// short yellow, judged against the length of the run that just ended.
module tlc_dir_checker
   import traffic_pkg::*;
#(
   parameter int unsigned MIN_GREEN  = 11,
   parameter int unsigned MIN_YELLOW = 4,
   parameter int unsigned CNT_W      = 6
) (
   input  logic [LIGHT_W-1:0] prev,
   input  logic [LIGHT_W-1:0] cur,
   input  logic [CNT_W-1:0]   cnt,
   output logic               illegal_c,
   output logic               bad_seq_c,
   output logic               short_green_c,
   output logic               short_yellow_c
);

   logic g_to_y;
   logic y_to_r;
   logic r_to_g;

   always_comb begin
      r_to_g = (prev == RED)    && (cur == GREEN);
      g_to_y = (prev == GREEN)  && (cur == YELLOW);
      y_to_r = (prev == YELLOW) && (cur == RED);

      illegal_c      = (cur == BAD_LIGHT);
      bad_seq_c      = (prev != cur) && !(r_to_g || g_to_y || y_to_r);
      short_green_c  = g_to_y && (cnt < CNT_W'(MIN_GREEN));
      short_yellow_c = y_to_r && (cnt < CNT_W'(MIN_YELLOW));
   end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor on the four intersection light buses; latches
// the first violation as a sticky fault and requests all-flash.
// Optional green-rotation order check enabled by defining TLC_ORDER_CHECK_EN.
module traffic_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned MIN_GREEN  = 11,
   parameter int unsigned MIN_YELLOW = 4,
   parameter int unsigned MAX_DWELL  = 12,
   parameter int unsigned CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ns_light,
   input  logic [1:0] ew_light,
   input  logic [1:0] sn_light,
   input  logic [1:0] we_light,
   input  logic       fault_clr,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] fault_dir,
   output logic       flash_req,
   output logic [7:0] viol_cnt
);

   light_vec_t         cur;
   light_vec_t         prev;
   logic [CNT_W-1:0]   cnt;

   logic [3:0]         illegal;
   logic [3:0]         bad_seq;
   logic [3:0]         short_green;
   logic [3:0]         short_yellow;
   logic [3:0]         nonred;
   logic               changed;
   logic               conflict;
   logic               dwell;
   logic [CODE_W-1:0]  viol_code;
   logic [DIR_W-1:0]   viol_dir;
   logic               viol;

   assign cur = {ns_light, ew_light, sn_light, we_light};

   for (genvar i = 0; i < 4; i++) begin : g_dir
      tlc_dir_checker #(
         .MIN_GREEN  (MIN_GREEN),
         .MIN_YELLOW (MIN_YELLOW),
         .CNT_W      (CNT_W)
      ) u_chk (
         .prev           (dir_light(prev, DIR_W'(i))),
         .cur            (dir_light(cur,  DIR_W'(i))),
         .cnt            (cnt),
         .illegal_c      (illegal[i]),
         .bad_seq_c      (bad_seq[i]),
         .short_green_c  (short_green[i]),
         .short_yellow_c (short_yellow[i])
      );
   end

`ifdef TLC_ORDER_CHECK_EN
   logic [DIR_W-1:0] last_dir;
   logic             last_valid;
   logic [3:0]       rise;
   logic [3:0]       bad_order;

   // A new green must be the successor of the previous green direction.
   always_comb begin
      rise      = '0;
      bad_order = '0;
      for (int i = 0; i < 4; i++) begin
         rise[i]      = (dir_light(prev, DIR_W'(i)) == RED) &&
                        (dir_light(cur,  DIR_W'(i)) == GREEN);
         bad_order[i] = rise[i] && last_valid &&
                        (DIR_W'(i) != DIR_W'(last_dir + DIR_W'(1)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_dir   <= NS;
         last_valid <= 1'b0;
      end else if (|rise) begin
         last_dir   <= low_idx(rise);
         last_valid <= 1'b1;
      end
   end
`endif

   // Parallel checks resolved by lowest code, then lowest direction.
   always_comb begin
      viol_code = FC_NONE;
      viol_dir  = NS;
      changed   = (cur != prev);
      nonred    = '0;
      for (int i = 0; i < 4; i++) begin
         nonred[i] = (dir_light(cur, DIR_W'(i)) != RED);
      end
      conflict = |(nonred & (nonred - 4'd1));
      dwell    = !changed && (cnt >= CNT_W'(MAX_DWELL));

      if (|illegal) begin
         viol_code = FC_ILLEGAL_CODE;
         viol_dir  = low_idx(illegal);
      end else if (conflict) begin
         viol_code = FC_CONFLICT;
         viol_dir  = low_idx(nonred);
      end else if (|bad_seq) begin
         viol_code = FC_BAD_SEQ;
         viol_dir  = low_idx(bad_seq);
      end else if (|short_green) begin
         viol_code = FC_SHORT_GREEN;
         viol_dir  = low_idx(short_green);
      end else if (|short_yellow) begin
         viol_code = FC_SHORT_YELLOW;
         viol_dir  = low_idx(short_yellow);
      end else if (dwell) begin
         viol_code = FC_DWELL_TIMEOUT;
         viol_dir  = low_idx(nonred);
      end
`ifdef TLC_ORDER_CHECK_EN
      else if (|bad_order) begin
         viol_code = FC_BAD_ORDER;
         viol_dir  = low_idx(bad_order);
      end
`endif
   end

   assign viol = (viol_code != FC_NONE);

   // History, run length, sticky fault latch and violation counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev       <= '0;
         cnt        <= '0;
         fault      <= 1'b0;
         flash_req  <= 1'b0;
         fault_code <= FC_NONE;
         fault_dir  <= NS;
         viol_cnt   <= '0;
      end else begin
         prev <= cur;

         if (changed) begin
            cnt <= CNT_W'(1);
         end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
         end

         // A violation coincident with a clear is latched as a fresh fault.
         if (viol && (!fault || fault_clr)) begin
            fault      <= 1'b1;
            flash_req  <= 1'b1;
            fault_code <= viol_code;
            fault_dir  <= viol_dir;
         end else if (fault_clr) begin
            fault      <= 1'b0;
            flash_req  <= 1'b0;
            fault_code <= FC_NONE;
            fault_dir  <= NS;
         end

         if (viol && (viol_cnt != '1)) begin
            viol_cnt <= viol_cnt + VCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: directed vector table,
// controller-accurate rounds and randomized stimulus against a reference model.
module tb_traffic_conflict_monitor;

   localparam int MIN_GREEN  = 11;
   localparam int MIN_YELLOW = 4;
   localparam int MAX_DWELL  = 12;
   localparam int CNT_MAX    = 63;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] ns_light = 2'd0;
   logic [1:0] ew_light = 2'd0;
   logic [1:0] sn_light = 2'd0;
   logic [1:0] we_light = 2'd0;
   logic       fault_clr = 1'b0;
   logic       fault;
   logic [2:0] fault_code;
   logic [1:0] fault_dir;
   logic       flash_req;
   logic [7:0] viol_cnt;

   int errors = 0;
   int checks = 0;

   traffic_conflict_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .ns_light   (ns_light),
      .ew_light   (ew_light),
      .sn_light   (sn_light),
      .we_light   (we_light),
      .fault_clr  (fault_clr),
      .fault      (fault),
      .fault_code (fault_code),
      .fault_dir  (fault_dir),
      .flash_req  (flash_req),
      .viol_cnt   (viol_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_prev[4];
   int c[4];
   int m_cnt, m_code, m_dir, m_viol, m_last;
   bit m_fault, m_lvalid;

   function automatic void model_reset();
      for (int d = 0; d < 4; d++) m_prev[d] = 0;
      m_cnt = 0; m_fault = 0; m_code = 0; m_dir = 0; m_viol = 0;
      m_last = 0; m_lvalid = 0;
   endfunction

   // Light sequence is the cycle RED(0) -> GREEN(1) -> YELLOW(2) -> RED.
   function automatic bit rule_hit(int k, int d, int nonred, bit changed);
      case (k)
         1: return c[d] == 3;
         2: return nonred > 1 && c[d] != 0;
         3: return c[d] != m_prev[d] &&
                   !(m_prev[d] < 3 && c[d] < 3 && c[d] == (m_prev[d] + 1) % 3);
         4: return m_prev[d] == 1 && c[d] == 2 && m_cnt < MIN_GREEN;
         5: return m_prev[d] == 2 && c[d] == 0 && m_cnt < MIN_YELLOW;
         6: return !changed && m_cnt >= MAX_DWELL && (c[d] != 0 || (nonred == 0 && d == 0));
`ifdef TLC_ORDER_CHECK_EN
         7: return m_prev[d] == 0 && c[d] == 1 && m_lvalid && d != (m_last + 1) % 4;
`endif
         default: return 0;
      endcase
   endfunction

   function automatic void model_step(bit clr);
      int code = 0, dir = 0, nonred = 0;
      bit changed = 0, found = 0;
      for (int d = 0; d < 4; d++) begin
         if (c[d] != 0) nonred++;
         if (c[d] != m_prev[d]) changed = 1;
      end
      for (int k = 1; k <= 7 && code == 0; k++)
         for (int d = 0; d < 4 && code == 0; d++)
            if (rule_hit(k, d, nonred, changed)) begin code = k; dir = d; end
      for (int d = 0; d < 4; d++)
         if (!found && m_prev[d] == 0 && c[d] == 1) begin
            found = 1; m_last = d; m_lvalid = 1;
         end
      if (code != 0 && (!m_fault || clr)) begin
         m_fault = 1; m_code = code; m_dir = dir;
      end else if (clr) begin
         m_fault = 0; m_code = 0; m_dir = 0;
      end
      if (code != 0 && m_viol < 255) m_viol++;
      m_cnt = changed ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
      for (int d = 0; d < 4; d++) m_prev[d] = c[d];
   endfunction

   // ---------------- helpers ----------------
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      cmp({tag, "_fault"}, 32'(fault), 32'(m_fault));
      cmp({tag, "_flash"}, 32'(flash_req), 32'(m_fault));
      cmp({tag, "_code"}, 32'(fault_code), 32'(m_code));
      cmp({tag, "_dir"}, 32'(fault_dir), 32'(m_dir));
      cmp({tag, "_viol"}, 32'(viol_cnt), 32'(m_viol));
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_fault"}, 32'(fault), 0);
      cmp({tag, "_flash"}, 32'(flash_req), 0);
      cmp({tag, "_code"}, 32'(fault_code), 0);
      cmp({tag, "_dir"}, 32'(fault_dir), 0);
      cmp({tag, "_viol"}, 32'(viol_cnt), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; fault_clr = 1'b0;
      ns_light = 2'd0; ew_light = 2'd0; sn_light = 2'd0; we_light = 2'd0;
      @(posedge clk); #1;
      check_zero("reset");
      rst = 1'b0;
      model_reset();
   endtask

   task automatic drive_step(input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] s, input logic [1:0] w, input logic clr);
      ns_light = a; ew_light = b; sn_light = s; we_light = w; fault_clr = clr;
      @(posedge clk); #1;
      c[0] = int'(a); c[1] = int'(b); c[2] = int'(s); c[3] = int'(w);
      model_step(clr);
      fault_clr = 1'b0;
   endtask

   function automatic logic [1:0] pick_light();
      int r = $urandom_range(0, 9);
      if (r <= 5) return 2'd0;
      if (r <= 7) return 2'd1;
      if (r == 8) return 2'd2;
      return 2'd3;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rst_first;
      int         rep;
      logic [1:0] ns, ew, sn, we;
      logic       clr;
      logic       e_fault;
      logic [2:0] e_code;
      logic [1:0] e_dir;
      logic [7:0] e_viol;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit r, int rep, logic [1:0] a, logic [1:0] b,
                               logic [1:0] s, logic [1:0] w, logic clr,
                               logic f, logic [2:0] code, logic [1:0] dir, logic [7:0] v);
      vec_t t;
      t.rst_first = r; t.rep = rep; t.ns = a; t.ew = b; t.sn = s; t.we = w;
      t.clr = clr; t.e_fault = f; t.e_code = code; t.e_dir = dir; t.e_viol = v;
      tbl.push_back(t);
   endfunction

   initial begin
      logic [1:0] v[4];

      // short green on NS
      add(1, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0);
      add(0, 1, 2, 0, 0, 0, 0,  1, 4, 0, 1);
      // conflict, then illegal code held off, then clear coincident with violation
      add(1, 1, 1, 1, 0, 0, 0,  1, 2, 0, 1);
      add(0, 1, 1, 1, 3, 0, 0,  1, 2, 0, 2);
      add(0, 1, 1, 1, 3, 0, 1,  1, 1, 2, 3);
      // EW green straight to red, then a clean clear
      add(1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0,  1, 3, 1, 1);
      add(0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1);
      // NS phase then WE green out of turn
      add(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 4, 2, 0, 0, 0, 0,  0, 0, 0, 0);
`ifdef TLC_ORDER_CHECK_EN
      add(0, 1, 0, 0, 0, 1, 0,  1, 7, 3, 1);
`else
      add(0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0);
`endif
      // SN green dwell timeout
      add(1, 12, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 1, 0, 0,  1, 6, 2, 1);
      add(0, 1, 0, 0, 1, 0, 0,  1, 6, 2, 2);

      foreach (tbl[i]) begin
         if (tbl[i].rst_first) do_reset();
         for (int r = 0; r < tbl[i].rep; r++) begin
            drive_step(tbl[i].ns, tbl[i].ew, tbl[i].sn, tbl[i].we, tbl[i].clr);
            cmp($sformatf("row%0d_fault", i), 32'(fault), 32'(tbl[i].e_fault));
            cmp($sformatf("row%0d_flash", i), 32'(flash_req), 32'(tbl[i].e_fault));
            cmp($sformatf("row%0d_code", i), 32'(fault_code), 32'(tbl[i].e_code));
            cmp($sformatf("row%0d_dir", i), 32'(fault_dir), 32'(tbl[i].e_dir));
            cmp($sformatf("row%0d_viol", i), 32'(viol_cnt), 32'(tbl[i].e_viol));
         end
      end

      // asynchronous reset while the dwell fault is latched
      rst = 1'b1;
      #2;
      check_zero("async_rst");

      // controller-accurate rotation, four full rounds
      do_reset();
      for (int r = 0; r < 4; r++)
         for (int d = 0; d < 4; d++)
            for (int k = 0; k < MIN_GREEN + MIN_YELLOW; k++) begin
               for (int j = 0; j < 4; j++) v[j] = 2'd0;
               v[d] = (k < MIN_GREEN) ? 2'd1 : 2'd2;
               drive_step(v[0], v[1], v[2], v[3], 1'b0);
               check_model("ctrl");
            end
      check_zero("ctrl_end");

      // violation counter saturation under a permanently illegal NS code
      do_reset();
      repeat (300) drive_step(2'd3, 2'd0, 2'd0, 2'd0, 1'b0);
      cmp("sat_viol", 32'(viol_cnt), 255);
      cmp("sat_code", 32'(fault_code), 1);
      cmp("sat_dir", 32'(fault_dir), 0);
      check_model("sat");

      // randomized stimulus against the reference model
      do_reset();
      for (int j = 0; j < 4; j++) v[j] = 2'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
            for (int j = 0; j < 4; j++) v[j] = 2'd0;
         end
         if ($urandom_range(0, 3) == 0)
            for (int j = 0; j < 4; j++) v[j] = pick_light();
         drive_step(v[0], v[1], v[2], v[3], logic'($urandom_range(0, 7) == 0));
         check_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
Independent safety checker on the four 2-bit light buses produced by the intersection controller. It samples ns/ew/sn/we light codes every cycle and checks for illegal codes, conflicting greens, illegal per-direction sequences, short green/yellow phases and stuck phases. On the first violation it latches a sticky fault with a code and a direction, and raises flash_req so the top level can force all-flash. It sits beside the controller at the top level and does not drive the controller.

Parameters:
MIN_GREEN, 11, minimum consecutive cycles a GREEN must be shown before YELLOW
MIN_YELLOW, 4, minimum consecutive cycles a YELLOW must be shown before RED
MAX_DWELL, 12, maximum consecutive cycles any unchanged light vector may persist; must be less than 63
CNT_W, 6, width of the run-length counter; saturates at 2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ns_light  in  2  north-south light code: 00 RED, 01 GREEN, 10 YELLOW, 11 illegal
ew_light  in  2  east-west light code, same encoding
sn_light  in  2  south-north light code, same encoding
we_light  in  2  west-east light code, same encoding
fault_clr  in  1  synchronous single-cycle clear of the latched fault
fault  out  1  sticky fault flag
fault_code  out  3  first fault cause: 0 none, 1 ILLEGAL_CODE, 2 CONFLICT, 3 BAD_SEQ, 4 SHORT_GREEN, 5 SHORT_YELLOW, 6 DWELL_TIMEOUT, 7 BAD_ORDER
fault_dir  out  2  direction of the first fault: 0 NS, 1 EW, 2 SN, 3 WE
flash_req  out  1  equals fault; registered
viol_cnt  out  8  saturating count of cycles that contain any violation

Behaviour:
- Reset is asynchronous, active-high, one clock only. Reset clears prev vector to all RED, run counter cnt to 0, and fault, fault_code, fault_dir, flash_req and viol_cnt to 0.
- Each cycle the monitor samples the 8-bit vector {ns,ew,sn,we} and compares it with prev. All outputs are registered. A violation in the sample taken at edge N is visible after edge N+1 (latency 1).
- Run counter: if the vector differs from prev, checks use cnt as the length of the finished run, then cnt is set to 1. Otherwise cnt saturates at 2^CNT_W-1 while incrementing. prev is updated with the vector every cycle.
- The checks below are evaluated in parallel. When several fire, the lowest code wins. Within a code, the lowest direction index wins.
  - ILLEGAL_CODE: any light equals 11.
  - CONFLICT: more than one light is non-RED. fault_dir is the lowest non-RED index.
  - BAD_SEQ: per direction, the allowed prev to cur pairs are: unchanged, RED to GREEN, GREEN to YELLOW, YELLOW to RED. Everything else is bad, e.g. GREEN to RED, YELLOW to GREEN, RED to YELLOW.
  - SHORT_GREEN: a direction goes GREEN to YELLOW with cnt < MIN_GREEN.
  - SHORT_YELLOW: a direction goes YELLOW to RED with cnt < MIN_YELLOW.
  - DWELL_TIMEOUT: the vector is unchanged and cnt >= MAX_DWELL. fault_dir is the non-RED direction, or 0 if all lights are RED.
- Fault latch:
  - When fault is 0 and a violation occurs: fault is set, code and dir are captured.
  - When fault is 1: later violations do not overwrite code or dir.
  - fault_clr clears fault, code and dir. If fault_clr and a violation occur in the same cycle, the violation wins and is latched fresh.
- viol_cnt increments on every violating cycle regardless of fault, and saturates at 255. fault_clr does not clear it; only rst does.
- First sample after reset: prev is all RED and cnt is 0, so an initial NS GREEN is a legal RED to GREEN transition.
- Reset mid-run: all state returns to reset values immediately. Checking restarts from the all-RED prev.

Optional Feature:
TLC_ORDER_CHECK_EN
- Defined: tracks last_dir, the last direction to go RED to GREEN, plus a valid bit. A new RED to GREEN on any direction other than (last_dir+1) mod 4 raises BAD_ORDER (code 7) with fault_dir set to the offending direction. The first green after reset sets last_dir without a check.
- Undefined: last_dir logic is absent and code 7 is never produced.

Decomposition:
- Shared package traffic_pkg holds:
  - light codes RED, GREEN, YELLOW
  - direction indices NS, EW, SN, WE
  - the fault code constants 0 to 7
- One natural sub-module, tlc_dir_checker, instantiated four times. It takes prev and cur for one direction plus cnt, and returns illegal, bad_seq, short_green and short_yellow flags.

Test Plan:
- Controller-accurate sequence (GREEN 11 cycles, YELLOW 4 cycles, NS to EW to SN to WE) for 4 full rounds: fault=0 and viol_cnt=0 throughout.
- NS GREEN held 5 cycles, then YELLOW: one cycle after the YELLOW sample, fault=1, fault_code=4, fault_dir=0, flash_req=1.
- ns=01 and ew=01 in the same cycle: fault_code=2, fault_dir=0. A following sn=11 must not change the code; viol_cnt increments on each bad cycle.
- EW goes GREEN straight to RED: fault_code=3, fault_dir=1. Then pulse fault_clr with no violation: fault=0 and code=0 the next cycle, while viol_cnt is held.
- SN GREEN held 13 cycles: fault_code=6, fault_dir=2 after the cycle in which cnt reaches 12. Asserting rst mid-fault clears every output asynchronously.
- With TLC_ORDER_CHECK_EN defined: after the NS phase, WE goes to GREEN, giving fault_code=7 and fault_dir=3. With the macro undefined, the same stimulus gives no fault.
